mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port memread  input  1  request is a word read.
REQ-008 SHALL have port memwrite  input  1  request is a word write.
REQ-009 SHALL have port address  input  32  byte address; word index = address[31:2].
REQ-010 SHALL have port writedata  input  32  store data.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port readdata  output  32  read result; 0 for writes and errors.
REQ-014 SHALL have port resp_err  output  1  request was rejected as illegal.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid & req_ready, registering memread, memwrite, address and writedata, and move to WAIT with the latency counter loaded to LATENCY-1.
REQ-017 SHALL decrement the counter each WAIT cycle and enter RESP on the cycle after it reaches 0, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-018 SHALL flag the request illegal when address[1:0] != 0, word index >= DEPTH, memread == memwrite (both or neither set).
REQ-019 SHALL, for a legal write, update memory[address[31:2]] with the registered writedata on the WAIT->RESP edge, returning readdata = 0 and resp_err = 0.
REQ-020 SHALL, for a legal read, sample memory[address[31:2]] on the WAIT->RESP edge into the readdata register, with resp_err = 0.
REQ-021 SHALL, for an illegal request, leave memory unchanged and return readdata = 0, resp_err = 1.
REQ-022 SHALL hold resp_valid, readdata and resp_err stable in RESP until resp_ready is sampled high, then return to IDLE on that edge.
REQ-023 SHALL not accept a new request on the same cycle a response is consumed; the next accept is possible one cycle later in IDLE.
REQ-024 SHALL ignore memread, memwrite, address and writedata outside the accept cycle; input changes during WAIT/RESP have no effect.
REQ-025 SHALL keep readdata and resp_err at 0 whenever resp_valid = 0.
REQ-026 SHALL initialise memory word i to value i at simulation start; memory contents are not altered by rst.

Reset
REQ-027 SHALL, on any clk edge with rst = 1, enter IDLE, clear the counter, and drive req_ready = 1, resp_valid = 0, readdata = 0, resp_err = 0 from the following cycle.
REQ-028 SHALL abort an in-flight request when rst is asserted in WAIT or RESP; a pending write whose commit edge coincides with rst SHALL NOT be performed.

Verification
REQ-029 SHALL pass: after reset, read address 0x20 with LATENCY=2, resp_ready=1 -> resp_valid high 2 cycles after accept, readdata = 8, resp_err = 0.
REQ-030 SHALL pass: write 0xDEADBEEF to 0x10, then read 0x10 -> second response readdata = 0xDEADBEEF; address 0x14 still reads 5.
REQ-031 SHALL pass: read 0x22 (misaligned), read 0x200 (index 128), memread = memwrite = 1 -> each responds resp_err = 1, readdata = 0, memory unchanged.
REQ-032 SHALL pass: hold resp_ready = 0 for 5 cycles in RESP while req_valid = 1 -> resp_valid, readdata stable, req_ready = 0, no second accept until after the response handshake.
REQ-033 SHALL pass: assert rst during WAIT of a write of 0x12345678 to 0x0 -> req_ready = 1, resp_valid = 0 next cycle; later read 0x0 returns 0.
REQ-034 SHALL pass: back-to-back requests with req_valid held high -> accepts occur every LATENCY+2 cycles with resp_ready = 1, responses in request order.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory target with a fixed
// request-to-response latency. Requests are checked for legality when the
// wait period ends; writes commit and reads sample on that same edge.
//
// Handshake semantics: a request transfers on a rising edge where
// req_valid && req_ready; a response transfers on a rising edge where
// resp_valid && resp_ready. While resp_valid is high, readdata and resp_err
// stay constant until that transfer edge. Request side fields are only
// looked at on the transfer edge.
module mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] readdata,
  output logic        resp_err,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef logic [DEPTH-1:0][31:0] mem_t;

  // Power-up contents: word i holds the value i. Reset never touches memory.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction

  mem_t        r_mem = mem_init();
  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_commit;
  logic        w_illegal;
  logic [29:0] w_idx;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  // The commit edge is the WAIT->RESP edge; a coincident reset cancels it.
  assign w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0) && !rst;
  assign w_idx     = r_addr[31:2];
  assign w_illegal = (r_addr[1:0] != 2'b00) ||
                     ({2'b00, w_idx} >= 32'(DEPTH)) ||
                     (r_rd == r_wr);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)      w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0)  w_next = S_RESP;
      S_RESP:  if (resp_ready)     w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  // Output logic: response fields are forced to zero outside RESP.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    resp_valid  = (r_state == S_RESP);
    readdata    = resp_valid ? r_rdata : 32'd0;
    resp_err    = resp_valid ? r_err : 1'b0;
    o_dbg_state = r_state;
  end

  // Latency counter: loaded on accept, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= 4'(LATENCY - 1);
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture: inputs are registered only on the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd    <= memread;
      r_wr    <= memwrite;
      r_addr  <= address;
      r_wdata <= writedata;
    end
  end

  // Memory write port: legal writes land on the commit edge.
  always_ff @(posedge clk) begin
    if (w_commit && !w_illegal && r_wr) begin
      r_mem[w_idx[AW-1:0]] <= r_wdata;
    end
  end

  // Response registers: loaded on the commit edge, cleared once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_illegal;
      r_rdata <= (!w_illegal && r_rd) ? r_mem[w_idx[AW-1:0]] : 32'd0;
    end else if ((r_state == S_RESP) && resp_ready) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

endmodule
